local_in_arbiter: RTL and testbench

Starvation-bounded arbiter that drains the north and south local-in FIFOs of a router node into the core's input buffer. North has priority, but a south packet waits for at most STARVE_LIMIT consecutive north grants. Downstream backpressure is honoured, and each grant is tracked through the FIFO read latency to an output write strobe. Sits between the router's north/south local FIFOs and the core input buffer; it replaces the fixed-priority merge and has the same packet format (dx/dy already stripped).

---
 rtl/local_in_arbiter.sv | 127 ++++++++++++
 tb/tb_local_in_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/local_in_arbiter.sv
// local_in_arbiter: merges the north and south local-in FIFOs into the core
// input buffer. North has priority; south is forced through after STARVE_LIMIT
// consecutive north grants. Optional output register stage: LOCAL_IN_OUT_REG_EN.
module local_in_arbiter #(
  parameter int unsigned PACKET_WIDTH = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] din_north,
  input  logic [PACKET_WIDTH-1:0] din_south,
  input  logic                    empty_north,
  input  logic                    empty_south,
  input  logic                    out_full,
  output logic                    ren_north,
  output logic                    ren_south,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic                    dout_wen,
  output logic                    starve_active
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    NORTH_PRI   = 1'b0,
    SOUTH_FORCE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_starve_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_gnt_n;
  logic                    w_gnt_s;
  logic                    r_sel_valid;
  logic                    r_sel_src;
  logic [PACKET_WIDTH-1:0] w_mux;

  // Grant selection: priority order flips while south is being forced.
  always_comb begin
    w_gnt_n = 1'b0;
    w_gnt_s = 1'b0;
    if (!out_full) begin
      if (r_state == SOUTH_FORCE) begin
        if (!empty_south)      w_gnt_s = 1'b1;
        else if (!empty_north) w_gnt_n = 1'b1;
      end else begin
        if (!empty_north)      w_gnt_n = 1'b1;
        else if (!empty_south) w_gnt_s = 1'b1;
      end
    end
  end

  // Read enables are suppressed while reset is held.
  assign ren_north     = w_gnt_n & rst;
  assign ren_south     = w_gnt_s & rst;
  assign starve_active = (r_state == SOUTH_FORCE);

  // Next-state and starvation counter; force south once the updated count hits the limit.
  always_comb begin
    w_cnt_nxt   = r_starve_cnt;
    w_state_nxt = r_state;
    if (empty_south || w_gnt_s) w_cnt_nxt = '0;
    else if (w_gnt_n)           w_cnt_nxt = r_starve_cnt + CNT_W'(1);
    case (r_state)
      NORTH_PRI: begin
        if (!empty_south && (w_cnt_nxt == LIMIT)) w_state_nxt = SOUTH_FORCE;
      end
      SOUTH_FORCE: begin
        if (w_gnt_s || empty_south) w_state_nxt = NORTH_PRI;
      end
      default: w_state_nxt = NORTH_PRI;
    endcase
  end

  // State, counter and grant-tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= NORTH_PRI;
      r_starve_cnt <= '0;
      r_sel_valid  <= 1'b0;
      r_sel_src    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
      r_sel_valid  <= w_gnt_n | w_gnt_s;
      r_sel_src    <= w_gnt_s;
    end
  end

  assign w_mux = r_sel_src ? din_south : din_north;

`ifdef LOCAL_IN_OUT_REG_EN
  logic [PACKET_WIDTH-1:0] r_dout;
  logic                    r_dout_wen;

  // Extra output stage: registers the selected FIFO word and its strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout     <= '0;
      r_dout_wen <= 1'b0;
    end else begin
      r_dout_wen <= r_sel_valid;
      if (r_sel_valid) r_dout <= w_mux;
    end
  end

  assign dout     = r_dout;
  assign dout_wen = r_dout_wen;
`else
  logic [PACKET_WIDTH-1:0] r_dout_last;

  // Remembers the last delivered word so dout holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout_last <= '0;
    end else if (r_sel_valid) begin
      r_dout_last <= w_mux;
    end
  end

  assign dout     = r_sel_valid ? w_mux : r_dout_last;
  assign dout_wen = r_sel_valid;
`endif

endmodule

// File: tb/tb_local_in_arbiter.sv
// Self-checking bench for local_in_arbiter: FIFO behaviour and expected grants
// come from queue-based models; honours LOCAL_IN_OUT_REG_EN for latency.
module tb_local_in_arbiter;

  localparam int unsigned PW    = 12;
  localparam int unsigned LIMIT = 4;
`ifdef LOCAL_IN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    bit          v;
    bit [PW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] din_north = '0;
  logic [PW-1:0] din_south = '0;
  logic          empty_north = 1'b1;
  logic          empty_south = 1'b1;
  logic          out_full = 1'b0;
  logic          ren_north, ren_south, dout_wen, starve_active;
  logic [PW-1:0] dout;

  bit [PW-1:0] nq[$];
  bit [PW-1:0] sq[$];
  ent_t        hist[$];
  int          consec;
  bit [PW-1:0] last_dout;
  string       glog;
  int          errors = 0;
  int          checks = 0;

  local_in_arbiter #(.PACKET_WIDTH(PW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .din_north(din_north), .din_south(din_south),
    .empty_north(empty_north), .empty_south(empty_south),
    .out_full(out_full),
    .ren_north(ren_north), .ren_south(ren_south),
    .dout(dout), .dout_wen(dout_wen), .starve_active(starve_active)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    ent_t z;
    z = '0;
    consec = 0;
    last_dout = '0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(z);
  endtask

  // One clock cycle: present flags, check grants/outputs against the model, emulate FIFO reads.
  task automatic step(input bit full);
    bit          gn, gs, exp_starve;
    ent_t        e, cur;
    bit [PW-1:0] exp_d;
    @(negedge clk);
    out_full    = full;
    empty_north = (nq.size() == 0);
    empty_south = (sq.size() == 0);
    #1;
    gn = 1'b0;
    gs = 1'b0;
    exp_starve = (consec >= int'(LIMIT));
    if (!full) begin
      if (exp_starve && sq.size() != 0) gs = 1'b1;
      else if (nq.size() != 0)          gn = 1'b1;
      else if (sq.size() != 0)          gs = 1'b1;
    end
    checks++;
    if (ren_north !== gn || ren_south !== gs) begin
      errors++;
      $display("FAIL grant: ren_n/s=%b%b expected %b%b at %0t", ren_north, ren_south, gn, gs, $time);
    end
    checks++;
    if (starve_active !== exp_starve) begin
      errors++;
      $display("FAIL starve_active: got %b expected %b at %0t", starve_active, exp_starve, $time);
    end
    e = hist.pop_front();
    exp_d = e.v ? e.d : last_dout;
    last_dout = exp_d;
    checks++;
    if (dout_wen !== e.v) begin
      errors++;
      $display("FAIL dout_wen: got %b expected %b at %0t", dout_wen, e.v, $time);
    end
    checks++;
    if (dout !== exp_d) begin
      errors++;
      $display("FAIL dout: got %h expected %h at %0t", dout, exp_d, $time);
    end
    if (sq.size() == 0 || gs) consec = 0;
    else if (gn)              consec++;
    cur.v = gn | gs;
    cur.d = '0;
    if (gn) begin cur.d = nq.pop_front(); glog = {glog, "N"}; end
    if (gs) begin cur.d = sq.pop_front(); glog = {glog, "S"}; end
    hist.push_back(cur);
    @(posedge clk);
    #1;
    din_north = gn ? cur.d : PW'($urandom);
    din_south = gs ? cur.d : PW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (nq.size() != 0 || sq.size() != 0); i++) step(1'b0);
    for (int i = 0; i < LAT + 1; i++) step(1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      nq.push_back(PW'($urandom));
      sq.push_back(PW'($urandom));
    end
    rst = 1'b0;
    empty_north = 1'b0;
    empty_south = 1'b0;
    out_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({ren_north, ren_south, dout_wen, starve_active} !== 4'b0 || dout !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ren=%b%b wen=%b starve=%b dout=%h expected all 0",
                 ren_north, ren_south, dout_wen, starve_active, dout);
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    glog = "";
    step(1'b0);
    checks++;
    if (glog != "N") begin
      errors++;
      $display("FAIL reset_first_grant: got '%s' expected 'N'", glog);
    end
    drain();
  endtask

  task automatic test_north_only();
    for (int i = 1; i <= 5; i++) nq.push_back(PW'(i));
    glog = "";
    drain();
    checks++;
    if (glog != "NNNNN") begin
      errors++;
      $display("FAIL north_only_pattern: got '%s' expected 'NNNNN'", glog);
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 10; i++) begin
      nq.push_back(PW'(12'h100 + i));
      sq.push_back(PW'(12'h200 + i));
    end
    glog = "";
    drain();
    checks++;
    if (glog != "NNNNSNNNNSNNSSSSSSSS") begin
      errors++;
      $display("FAIL starve_pattern: got '%s' expected 'NNNNSNNNNSNNSSSSSSSS'", glog);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      nq.push_back(PW'($urandom));
      sq.push_back(PW'($urandom));
    end
    glog = "";
    for (int i = 0; i < 16; i++) step(i[0] == 1'b0);
    checks++;
    if (glog.len() != 8) begin
      errors++;
      $display("FAIL backpressure_grants: got %0d expected 8", glog.len());
    end
    drain();
  endtask

  task automatic test_force_empty();
    for (int i = 0; i < 6; i++) nq.push_back(PW'(12'h300 + i));
    sq.push_back(12'h3ff);
    glog = "";
    for (int i = 0; i < 4; i++) step(1'b0);
    void'(sq.pop_front());
    step(1'b0);
    step(1'b0);
    checks++;
    if (glog != "NNNNNN" || consec != 0) begin
      errors++;
      $display("FAIL force_empty: got '%s' consec=%0d expected 'NNNNNN' consec=0", glog, consec);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) nq.push_back(PW'($urandom));
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dout_wen !== 1'b0 || dout !== '0 || ren_north !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: wen=%b dout=%h ren_n=%b expected 0,0,0", dout_wen, dout, ren_north);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) nq.push_back(PW'($urandom));
      if ($urandom_range(0, 2) == 0) sq.push_back(PW'($urandom));
      step($urandom_range(0, 4) == 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_north_only();
    test_starve();
    test_backpressure();
    test_force_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
